exe_stage_hs: RTL and testbench

//  Parametrised RV32I/M execute stage with a registered EX/MEM output and a valid/ready handshake.

---
 rtl/exe_stage_hs.sv | 188 ++++++++++++++++++
 tb/tb_exe_stage_hs.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_hs.sv
// Execute stage: operand forwarding, single-cycle ALU, registered EX/MEM output
// with a valid/ready handshake.
// Optional feature macro: EXE_MUL_EN. When defined, it builds an iterative shift-add unit
// for MUL/MULHU. While that unit runs, the stage stalls upstream.
module exe_stage_hs #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rda,
    input  logic [XLEN-1:0] rdb,
    input  logic [XLEN-1:0] imm,
    input  logic            alusrc,
    input  logic [1:0]      aluop,
    input  logic            instr30,
    input  logic            instr25,
    input  logic [2:0]      funct3,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] fwd_mem,
    input  logic [XLEN-1:0] fwd_wb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    logic [XLEN-1:0] op_a, op_b_fwd, op_b, alu_res, mul_res, out_result_q;
    logic [SHW-1:0]  shamt;
    logic            out_valid_q, accept, is_mul, mul_idle, mul_done, out_free;

    // Forwarding muxes: 01 picks the MEM-stage result, 10 picks the WB data, else the register file.
    always_comb begin
        op_a = rda;
        op_b_fwd = rdb;
        case (fwd_a)
            2'b01:   op_a = fwd_mem;
            2'b10:   op_a = fwd_wb;
            default: op_a = rda;
        endcase
        case (fwd_b)
            2'b01:   op_b_fwd = fwd_mem;
            2'b10:   op_b_fwd = fwd_wb;
            default: op_b_fwd = rdb;
        endcase
        op_b = alusrc ? imm : op_b_fwd;
    end

    // Single-cycle ALU decode.
    always_comb begin
        alu_res = '0;
        shamt = op_b[SHW-1:0];
        case (aluop)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            default: begin
                case (funct3)
                    3'b000: alu_res = (aluop == 2'b10 && instr30) ? op_a - op_b : op_a + op_b;
                    3'b001: alu_res = op_a << shamt;
                    3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    3'b011: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
                    3'b100: alu_res = op_a ^ op_b;
                    3'b101: begin
                        // Kept as separate branches so the signed shift is not made unsigned.
                        if (instr30) alu_res = $signed(op_a) >>> shamt;
                        else         alu_res = op_a >> shamt;
                    end
                    3'b110: alu_res = op_a | op_b;
                    default: alu_res = op_a & op_b;
                endcase
            end
        endcase
    end

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = mul_idle && out_free && !flush;
    assign accept   = in_valid && in_ready;

`ifdef EXE_MUL_EN
    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e            state_q, state_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0] prod_q, prod_d, step_prod;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic              hi_q, hi_d;
    logic [XLEN:0]     step_sum;

    assign is_mul = (aluop == 2'b10) && instr25 && (funct3 == 3'b000 || funct3 == 3'b011);

    // Multiplier FSM: one shift-add step per cycle, the product shifts right through prod.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        mul_done = 1'b0;
        step_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        step_prod = {step_sum, prod_q[XLEN-1:1]};
        case (state_q)
            StIdle: begin
                if (accept && is_mul) begin
                    state_d = StMul;
                    cnt_d   = '0;
                    prod_d  = {{XLEN{1'b0}}, op_b};
                    mcand_d = op_a;
                    hi_d    = (funct3 == 3'b011);
                end
            end
            StMul: begin
                if (cnt_q != SHW'(XLEN - 1)) begin
                    prod_d = step_prod;
                    cnt_d  = cnt_q + 1'b1;
                end else if (out_free) begin
                    // The final step is only taken when the output register can take the result.
                    prod_d   = step_prod;
                    cnt_d    = '0;
                    state_d  = StIdle;
                    mul_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d  = StIdle;
            cnt_d    = '0;
            mul_done = 1'b0;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            hi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
        end
    end

    assign mul_res  = hi_q ? step_prod[2*XLEN-1:XLEN] : step_prod[XLEN-1:0];
    assign mul_idle = (state_q == StIdle);
    assign busy     = (state_q == StMul);
`else
    logic unused_instr25;

    assign unused_instr25 = instr25;
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
    assign mul_idle = 1'b1;
    assign busy     = 1'b0;
`endif

    // EX/MEM output register: load on ALU accept or multiply completion, clear when drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid_q  <= 1'b1;
            out_result_q <= alu_res;
        end else if (mul_done) begin
            out_valid_q  <= 1'b1;
            out_result_q <= mul_res;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;

endmodule

// File: tb/tb_exe_stage_hs.sv
// Self-checking bench for exe_stage_hs: table-driven ALU vectors through a scoreboard,
// plus hand-written handshake, flush and (with EXE_MUL_EN) multiply sequences.
module tb_exe_stage_hs;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, alusrc, instr30, instr25;
    logic [XLEN-1:0] rda, rdb, imm, fwd_mem, fwd_wb, out_result;
    logic [1:0]      aluop, fwd_a, fwd_b;
    logic [2:0]      funct3;
    logic            out_valid, out_ready, busy;

    typedef struct {
        logic [31:0] rda, rdb, imm;
        logic        alusrc;
        logic [1:0]  aluop;
        logic        instr30, instr25;
        logic [2:0]  funct3;
        logic [1:0]  fwd_a, fwd_b;
        logic [31:0] fwd_mem, fwd_wb, exp;
    } vec_t;

    vec_t        vecs[14];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    exe_stage_hs #(.XLEN(XLEN), .SHW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rda(rda), .rdb(rdb), .imm(imm), .alusrc(alusrc), .aluop(aluop),
        .instr30(instr30), .instr25(instr25), .funct3(funct3), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .fwd_mem(fwd_mem), .fwd_wb(fwd_wb), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                                input logic src, input logic [1:0] op, input logic i30,
                                input logic i25, input logic [2:0] f3, input logic [1:0] fa,
                                input logic [1:0] fb, input logic [31:0] fm,
                                input logic [31:0] fw, input logic [31:0] e);
        vec_t v;
        v.rda = a; v.rdb = b; v.imm = im; v.alusrc = src; v.aluop = op; v.instr30 = i30;
        v.instr25 = i25; v.funct3 = f3; v.fwd_a = fa; v.fwd_b = fb; v.fwd_mem = fm;
        v.fwd_wb = fw; v.exp = e;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rda = v.rda; rdb = v.rdb; imm = v.imm; alusrc = v.alusrc; aluop = v.aluop;
        instr30 = v.instr30; instr25 = v.instr25; funct3 = v.funct3; fwd_a = v.fwd_a;
        fwd_b = v.fwd_b; fwd_mem = v.fwd_mem; fwd_wb = v.fwd_wb;
        in_valid = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Scoreboard: a transfer happens on the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got 0x%08h, expected no output", out_result);
            end else begin
                check("scoreboard_result", out_result, exp_q.pop_front());
            end
        end
    end

    initial begin
        int busy_cnt, first_valid, ir_bad, valid_cnt;

        vecs[0]  = mk(5, 3, 0, 0, 2'b10, 1, 0, 3'b000, 2'b00, 2'b00, 0, 0, 32'd2);
        vecs[1]  = mk(32'hAAAA, 32'h5555, 0, 0, 2'b10, 0, 0, 3'b110, 2'b01, 2'b10,
                      32'h10, 32'h01, 32'h11);
        vecs[2]  = mk(32'h80000000, 32'h24, 0, 0, 2'b10, 1, 0, 3'b101, 2'b00, 2'b00, 0, 0,
                      32'hF8000000);
        vecs[3]  = mk(32'hFFFFFFFF, 1, 0, 0, 2'b10, 0, 1, 3'b010, 2'b00, 2'b00, 0, 0, 32'd1);
        vecs[4]  = mk(32'hFFFFFFFF, 1, 0, 0, 2'b10, 0, 0, 3'b011, 2'b00, 2'b00, 0, 0, 32'd0);
        vecs[5]  = mk(32'hFFFFFFFF, 2, 0, 0, 2'b00, 1, 0, 3'b111, 2'b00, 2'b00, 0, 0, 32'd1);
        vecs[6]  = mk(3, 5, 0, 0, 2'b01, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 32'hFFFFFFFE);
        vecs[7]  = mk(10, 0, 32'hFFFFFFFF, 1, 2'b11, 1, 0, 3'b000, 2'b00, 2'b00, 0, 0, 32'd9);
        vecs[8]  = mk(1, 32'h21, 0, 0, 2'b10, 0, 0, 3'b001, 2'b00, 2'b00, 0, 0, 32'd2);
        vecs[9]  = mk(32'h80000000, 4, 0, 0, 2'b10, 0, 0, 3'b101, 2'b00, 2'b00, 0, 0,
                      32'h08000000);
        vecs[10] = mk(32'hF0F0, 32'hFF00, 0, 0, 2'b10, 0, 0, 3'b100, 2'b00, 2'b00, 0, 0,
                      32'h0FF0);
        vecs[11] = mk(32'h1234, 0, 32'hFF, 1, 2'b11, 0, 0, 3'b111, 2'b00, 2'b00, 0, 0, 32'h34);
        vecs[12] = mk(7, 0, 0, 0, 2'b00, 0, 0, 3'b000, 2'b11, 2'b01, 32'd99, 0, 32'd106);
        vecs[13] = mk(1, 0, 5, 1, 2'b00, 0, 0, 3'b000, 2'b00, 2'b01, 32'd100, 0, 32'd6);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(vecs[0]);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_result", out_result, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back ALU vectors at full throughput.
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            exp_q.push_back(vecs[i].exp);
            @(negedge clk);
            check($sformatf("in_ready_vec%0d", i), in_ready, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain("alu_drain");
        @(posedge clk);
        @(negedge clk);
        check("valid_clears_after_drain", out_valid, 0);

        // Output hold under back-pressure, then drain and accept on the same edge.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(mk(1, 1, 0, 0, 2'b00, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 32'd2));
        exp_q.push_back(32'd2);
        @(posedge clk); #1;
        drive(mk(4, 4, 0, 0, 2'b00, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 32'd8));
        exp_q.push_back(32'd8);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_result", out_result, 2);
            check("hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_out_valid", out_valid, 1);
        wait_drain("hold_drain");

        // Flush kills the held result and blocks the op presented during it.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(mk(1, 2, 0, 0, 2'b00, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 32'd3));
        @(posedge clk); #1;
        drive(mk(5, 5, 0, 0, 2'b00, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 32'd10));
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        check("preflush_out_valid", out_valid, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("postflush_out_valid", out_valid, 0);
        check("postflush_in_ready", in_ready, 1);
        out_ready = 1'b1;

`ifdef EXE_MUL_EN
        // MULHU: 33-edge latency, busy for 32 cycles, upstream stalled meanwhile.
        @(posedge clk); #1;
        drive(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 2'b10, 0, 1, 3'b011, 2'b00, 2'b00, 0, 0, 0));
        exp_q.push_back(32'hFFFFFFFE);
        @(posedge clk); #1;
        in_valid = 1'b0;
        busy_cnt = 0; first_valid = -1; ir_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (busy && in_ready) ir_bad++;
            if (out_valid && first_valid < 0) first_valid = k;
        end
        check("mulhu_busy_cycles", busy_cnt, 32);
        check("mulhu_first_valid", first_valid, 32);
        check("mulhu_in_ready_stall", ir_bad, 0);
        wait_drain("mulhu_drain");

        // MUL low word.
        @(posedge clk); #1;
        drive(mk(7, 6, 0, 0, 2'b10, 0, 1, 3'b000, 2'b00, 2'b00, 0, 0, 0));
        exp_q.push_back(32'd42);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain("mul_drain");

        // Flush, then reset, ten cycles into a multiply: no result ever appears.
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk); #1;
            drive(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 2'b10, 0, 1, 3'b011, 2'b00, 2'b00,
                     0, 0, 0));
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (9) @(posedge clk);
            #1;
            if (pass == 0) flush = 1'b1;
            else           rst = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            rst = 1'b0;
            @(negedge clk);
            check($sformatf("abort%0d_busy", pass), busy, 0);
            check($sformatf("abort%0d_in_ready", pass), in_ready, 1);
            valid_cnt = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (out_valid) valid_cnt++;
            end
            check($sformatf("abort%0d_no_result", pass), valid_cnt, 0);
        end
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
